// File: rtl/ap_host_port.sv
// ap_host_port -- associative-processor host port with two banks of A/B/C
// word columns and a cell-serial compute engine (C[i] = A[i] op B[i]).
//
// Parameters
//   WORD_SIZE   operand / result width in bits
//   CELL_QUANT  words per column per bank
//   ADDR_W      derived address width: bits needed to hold CELL_QUANT
//
// Ports
//   CLK100MHZ         in   sole clock, rising edge
//   rst_n             in   synchronous active-low reset (control state only;
//                          A/B/C storage is never cleared)
//   addr_in           in   cell index for host write/read
//   data_in           in   host write data
//   write_en          in   host write strobe (IDLE only)
//   read_en           in   host read strobe (IDLE only, write has priority)
//   sel_col           in   column select 0=A 1=B 2=C 3=none
//   sel_internal_col  in   bank select
//   ap_mode           in   0=host access, 1=compute request
//   cmd               in   0 OR 1 XOR 2 AND 3 NOT 4 ADD 5 SUB 6 MULT
//   data_out          out  registered read data, holds when not valid
//   data_valid        out  one-cycle pulse qualifying data_out
//   busy              out  high while computing
//   ap_state_irq      out  compute-complete level, high while in DONE
//
// Configuration macro
//   AP_MULT_EN  when defined, cmd 6 yields the low WORD_SIZE bits of A*B;
//               otherwise no multiplier exists and cmds 6/7 act as OR.
module ap_host_port #(
  parameter int WORD_SIZE  = 8,
  parameter int CELL_QUANT = 512,
  localparam int ADDR_W    = $clog2(CELL_QUANT + 1)
) (
  input  logic                 CLK100MHZ,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr_in,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic [1:0]           sel_col,
  input  logic                 sel_internal_col,
  input  logic                 ap_mode,
  input  logic [2:0]           cmd,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 ap_state_irq
);

  localparam int IDX_W = $clog2(CELL_QUANT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_QUANT - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  function automatic logic [WORD_SIZE-1:0] alu_op(
    input logic [2:0]           op,
    input logic [WORD_SIZE-1:0] a,
    input logic [WORD_SIZE-1:0] b
  );
    logic [WORD_SIZE-1:0] res;
    res = a | b;
    case (op)
      3'd1: res = a ^ b;
      3'd2: res = a & b;
      3'd3: res = ~a;
      3'd4: res = a + b;   // wraps modulo 2^WORD_SIZE
      3'd5: res = a - b;
`ifdef AP_MULT_EN
      3'd6: res = a * b;   // result context keeps only the low word
`endif
      default: res = a | b;
    endcase
    return res;
  endfunction

  logic [WORD_SIZE-1:0] r_mem_a [0:1][0:CELL_QUANT-1];
  logic [WORD_SIZE-1:0] r_mem_b [0:1][0:CELL_QUANT-1];
  logic [WORD_SIZE-1:0] r_mem_c [0:1][0:CELL_QUANT-1];

  state_t               r_state;
  logic [2:0]           r_cmd;
  logic                 r_bank;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_issued;     // every cell has been fetched
  logic                 r_vld_p0;
  logic [IDX_W-1:0]     r_idx_p0;
  logic [WORD_SIZE-1:0] r_a_p0;
  logic [WORD_SIZE-1:0] r_b_p0;
  logic [WORD_SIZE-1:0] r_data_out;
  logic                 r_data_valid;
  logic                 r_busy;
  logic                 r_irq;

  logic                 w_addr_ok;
  logic [IDX_W-1:0]     w_addr;
  logic                 w_host_wr;
  logic                 w_host_rd;
  logic                 w_issue;
  logic [WORD_SIZE-1:0] w_rd_data;

  // Addresses beyond the array are treated like sel_col=3: no write, read 0.
  assign w_addr_ok = (addr_in < ADDR_W'(CELL_QUANT));
  assign w_addr    = addr_in[IDX_W-1:0];
  // A compute request in IDLE takes precedence over host strobes.
  assign w_host_wr = (r_state == S_IDLE) && !ap_mode && write_en &&
                     w_addr_ok && (sel_col != 2'd3);
  assign w_host_rd = (r_state == S_IDLE) && !ap_mode && read_en && !write_en;
  assign w_issue   = (r_state == S_COMPUTE) && !r_issued;

  always_comb begin
    w_rd_data = '0;
    if (w_addr_ok) begin
      case (sel_col)
        2'd0:    w_rd_data = r_mem_a[sel_internal_col][w_addr];
        2'd1:    w_rd_data = r_mem_b[sel_internal_col][w_addr];
        2'd2:    w_rd_data = r_mem_c[sel_internal_col][w_addr];
        default: w_rd_data = '0;
      endcase
    end
  end

  // Control: FSM, cell counter, host read port and status outputs.
  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_bank       <= 1'b0;
      r_idx        <= '0;
      r_issued     <= 1'b0;
      r_vld_p0     <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_vld_p0     <= w_issue;
      case (r_state)
        S_IDLE: begin
          if (ap_mode) begin
            r_cmd    <= cmd;
            r_bank   <= sel_internal_col;
            r_idx    <= '0;
            r_issued <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_COMPUTE;
          end else if (w_host_rd) begin
            r_data_out   <= w_rd_data;
            r_data_valid <= 1'b1;
          end
        end
        S_COMPUTE: begin
          if (r_issued) begin
            // The last result is written on this same edge.
            r_busy  <= 1'b0;
            r_irq   <= 1'b1;
            r_state <= S_DONE;
          end else if (r_idx == LAST_IDX) begin
            r_issued <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          // Leaving only on ap_mode=0 guarantees a fresh 0->1 for the next run.
          if (!ap_mode) begin
            r_irq   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: fetch A/B of the current cell; stage p1: write C.
  always_ff @(posedge CLK100MHZ) begin
    if (w_issue) begin
      r_a_p0   <= r_mem_a[r_bank][r_idx];
      r_b_p0   <= r_mem_b[r_bank][r_idx];
      r_idx_p0 <= r_idx;
    end
    if (r_vld_p0) begin
      r_mem_c[r_bank][r_idx_p0] <= alu_op(r_cmd, r_a_p0, r_b_p0);
    end
    if (w_host_wr) begin
      case (sel_col)
        2'd0:    r_mem_a[sel_internal_col][w_addr] <= data_in;
        2'd1:    r_mem_b[sel_internal_col][w_addr] <= data_in;
        2'd2:    r_mem_c[sel_internal_col][w_addr] <= data_in;
        default: ;
      endcase
    end
  end

  assign data_out     = r_data_out;
  assign data_valid   = r_data_valid;
  assign busy         = r_busy;
  assign ap_state_irq = r_irq;

endmodule

// File: tb/tb_ap_host_port.sv
// Self-checking bench for ap_host_port: a cycle-level reference model of
// the host port plus directed vectors with hand-computed results.
module tb_ap_host_port;

  localparam int WS = 8;
  localparam int CQ = 512;
  localparam int AW = 10;

  logic          CLK100MHZ = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [WS-1:0] data_in = '0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [1:0]    sel_col = 2'd0;
  logic          sel_internal_col = 1'b0;
  logic          ap_mode = 1'b0;
  logic [2:0]    cmd = 3'd0;
  logic [WS-1:0] data_out;
  logic          data_valid;
  logic          busy;
  logic          ap_state_irq;

  ap_host_port #(.WORD_SIZE(WS), .CELL_QUANT(CQ)) dut (
    .CLK100MHZ        (CLK100MHZ),
    .rst_n            (rst_n),
    .addr_in          (addr_in),
    .data_in          (data_in),
    .write_en         (write_en),
    .read_en          (read_en),
    .sel_col          (sel_col),
    .sel_internal_col (sel_internal_col),
    .ap_mode          (ap_mode),
    .cmd              (cmd),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .busy             (busy),
    .ap_state_irq     (ap_state_irq)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WS-1:0] mA [2][CQ];
  logic [WS-1:0] mB [2][CQ];
  logic [WS-1:0] mC [2][CQ];
  int            m_phase = 0;   // 0 idle, 1 computing, 2 done
  int            m_cnt = 0;     // edges elapsed since the compute request
  int            m_cmd = 0;
  int            m_bank = 0;
  logic [WS-1:0] e_do = '0;
  logic          e_dv = 1'b0;
  logic          e_busy = 1'b0;
  logic          e_irq = 1'b0;
  bit            chk_en = 1'b0;

  function automatic logic [WS-1:0] op_ref(input int c, input logic [WS-1:0] a, input logic [WS-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    case (c)
      1: return a ^ b;
      2: return a & b;
      3: return ~a;
      4: return WS'((ia + ib) % 256);
      5: return WS'((ia - ib + 256) % 256);
`ifdef AP_MULT_EN
      6: return WS'((ia * ib) % 256);
`endif
      default: return a | b;
    endcase
  endfunction

  task automatic apply_cells(input int n);
    for (int i = 0; i < n; i++)
      mC[m_bank][i] = op_ref(m_cmd, mA[m_bank][i], mB[m_bank][i]);
  endtask

  always @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      // An aborted run leaves behind exactly the cells finished so far.
      if (m_phase == 1) apply_cells(m_cnt);
      m_phase = 0;
      e_do = '0;
      e_dv = 1'b0;
      e_busy = 1'b0;
      e_irq = 1'b0;
    end else begin
      e_dv = 1'b0;
      case (m_phase)
        0: begin
          if (ap_mode) begin
            m_cmd = int'(cmd);
            m_bank = int'(sel_internal_col);
            m_cnt = 0;
            m_phase = 1;
            e_busy = 1'b1;
          end else if (write_en) begin
            if (int'(addr_in) < CQ) begin
              case (sel_col)
                2'd0: mA[sel_internal_col][int'(addr_in)] = data_in;
                2'd1: mB[sel_internal_col][int'(addr_in)] = data_in;
                2'd2: mC[sel_internal_col][int'(addr_in)] = data_in;
                default: ;
              endcase
            end
          end else if (read_en) begin
            e_do = '0;
            if (int'(addr_in) < CQ) begin
              case (sel_col)
                2'd0: e_do = mA[sel_internal_col][int'(addr_in)];
                2'd1: e_do = mB[sel_internal_col][int'(addr_in)];
                2'd2: e_do = mC[sel_internal_col][int'(addr_in)];
                default: e_do = '0;
              endcase
            end
            e_dv = 1'b1;
          end
        end
        1: begin
          m_cnt++;
          if (m_cnt == CQ + 1) begin
            apply_cells(CQ);
            m_phase = 2;
            e_busy = 1'b0;
            e_irq = 1'b1;
          end
        end
        default: begin
          if (!ap_mode) begin
            m_phase = 0;
            e_irq = 1'b0;
          end
        end
      endcase
    end
  end

  always @(negedge CLK100MHZ) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("irq", 32'(ap_state_irq), 32'(e_irq));
      chk("data_valid", 32'(data_valid), 32'(e_dv));
      chk("data_out", 32'(data_out), 32'(e_do));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic we, input logic re, input logic bk,
                       input logic [1:0] col, input int addr, input logic [WS-1:0] d);
    @(negedge CLK100MHZ);
    write_en = we;
    read_en = re;
    sel_internal_col = bk;
    sel_col = col;
    addr_in = AW'(addr);
    data_in = d;
    ap_mode = 1'b0;
  endtask

  task automatic host_read(input logic bk, input logic [1:0] col, input int addr,
                           output logic [WS-1:0] d, output logic v);
    drive(1'b0, 1'b1, bk, col, addr, '0);
    @(negedge CLK100MHZ);
    d = data_out;
    v = data_valid;
    read_en = 1'b0;
  endtask

  task automatic read_expect(input string nm, input logic bk, input logic [1:0] col,
                             input int addr, input logic [WS-1:0] req);
    logic [WS-1:0] d;
    logic v;
    host_read(bk, col, addr, d, v);
    chk(nm, 32'(d), 32'(req));
  endtask

  // Request a compute, scramble host inputs while it runs, and report how
  // many edges after the request edge the irq was first seen.
  task automatic run_compute(input logic bk, input logic [2:0] c, output int edges);
    @(negedge CLK100MHZ);
    write_en = 1'b0;
    read_en = 1'b0;
    ap_mode = 1'b1;
    cmd = c;
    sel_internal_col = bk;
    @(negedge CLK100MHZ);
    edges = 0;
    while (edges < 600) begin
      write_en = 1'($urandom_range(0, 1));
      read_en = 1'($urandom_range(0, 1));
      cmd = 3'($urandom_range(0, 7));
      sel_internal_col = 1'($urandom_range(0, 1));
      sel_col = 2'($urandom_range(0, 3));
      addr_in = AW'($urandom_range(0, CQ - 1));
      data_in = WS'($urandom_range(0, 255));
      @(negedge CLK100MHZ);
      edges++;
      if (ap_state_irq) break;
    end
    write_en = 1'b0;
    read_en = 1'b0;
    cmd = c;
    if (!ap_state_irq) chk("irq_timeout", 32'(ap_state_irq), 32'd1);
  endtask

  task automatic finish_compute();
    @(negedge CLK100MHZ);
    ap_mode = 1'b0;
    @(negedge CLK100MHZ);
  endtask

  initial begin
    int edges;
    int seen;
    logic [WS-1:0] d;
    logic v;
    logic [WS-1:0] c99_before;
`ifdef AP_MULT_EN
    logic [WS-1:0] c2_req = 8'd17;
`else
    logic [WS-1:0] c2_req = 8'd29;
`endif

    repeat (2) @(negedge CLK100MHZ);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(ap_state_irq), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    for (int i = 0; i < CQ; i++) begin
      drive(1'b1, 1'b0, 1'b0, 2'd0, i, WS'(i * 7 + 3));
      drive(1'b1, 1'b0, 1'b0, 2'd1, i, WS'(i * 13 + 5));
      drive(1'b1, 1'b0, 1'b0, 2'd2, i, WS'(8'h55 ^ i));
      drive(1'b1, 1'b0, 1'b1, 2'd0, i, WS'(i * 3 + 1));
      drive(1'b1, 1'b0, 1'b1, 2'd1, i, WS'(i * 11 + 2));
      drive(1'b1, 1'b0, 1'b1, 2'd2, i, 8'hAA);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 0, 8'd171);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 0, 8'd167);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1, 8'h0F);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 2, 8'd13);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 2, 8'd21);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 5, 8'd10);
    drive(1'b1, 1'b0, 1'b0, 2'd1, 5, 8'd20);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 0, '0);

    // ADD on bank 0, irq latency and hold behaviour
    run_compute(1'b0, 3'd4, edges);
    chk("irq_latency", 32'(edges), 32'd513);
    repeat (20) @(negedge CLK100MHZ);
    chk("irq_hold", 32'(ap_state_irq), 32'd1);
    chk("no_recompute_busy", 32'(busy), 32'd0);
    ap_mode = 1'b0;
    @(negedge CLK100MHZ);
    chk("irq_clear", 32'(ap_state_irq), 32'd0);
    host_read(1'b0, 2'd2, 0, d, v);
    chk("add_c0", 32'(d), 32'd82);
    chk("read_valid", 32'(v), 32'd1);
    @(negedge CLK100MHZ);
    chk("read_valid_pulse", 32'(data_valid), 32'd0);

    run_compute(1'b0, 3'd0, edges);
    finish_compute();
    read_expect("or_c0", 1'b0, 2'd2, 0, 8'd175);

    run_compute(1'b0, 3'd5, edges);
    finish_compute();
    read_expect("sub_c5", 1'b0, 2'd2, 5, 8'd246);

    run_compute(1'b0, 3'd3, edges);
    finish_compute();
    read_expect("not_c1", 1'b0, 2'd2, 1, 8'hF0);

    run_compute(1'b0, 3'd6, edges);
    finish_compute();
    read_expect("cmd6_c2", 1'b0, 2'd2, 2, c2_req);

    // XOR on bank 1 leaves bank 0 untouched
    run_compute(1'b1, 3'd1, edges);
    finish_compute();
    read_expect("bank1_xor_c3", 1'b1, 2'd2, 3, 8'd41);
    read_expect("bank0_c2_kept", 1'b0, 2'd2, 2, c2_req);

    // simultaneous write and read: write only
    drive(1'b1, 1'b1, 1'b0, 2'd0, 9, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 0, '0);
    chk("wr_rd_no_valid", 32'(data_valid), 32'd0);
    read_expect("wr_rd_landed", 1'b0, 2'd0, 9, 8'h3C);

    // column 3 discards writes and reads as zero
    drive(1'b1, 1'b0, 1'b0, 2'd3, 9, 8'h77);
    read_expect("col3_read", 1'b0, 2'd3, 9, 8'h00);
    read_expect("col3_no_write", 1'b0, 2'd0, 9, 8'h3C);

    // reset at compute cycle 100 aborts an AND run on bank 0
    host_read(1'b0, 2'd2, 99, c99_before, v);
    @(negedge CLK100MHZ);
    ap_mode = 1'b1;
    cmd = 3'd2;
    sel_internal_col = 1'b0;
    @(negedge CLK100MHZ);
    repeat (99) @(negedge CLK100MHZ);
    rst_n = 1'b0;
    ap_mode = 1'b0;
    @(negedge CLK100MHZ);
    chk("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK100MHZ);
      if (ap_state_irq) seen++;
    end
    chk("abort_no_irq", 32'(seen), 32'd0);
    read_expect("abort_c0", 1'b0, 2'd2, 0, 8'd163);
    for (int i = 1; i < 99; i++) host_read(1'b0, 2'd2, i, d, v);
    read_expect("abort_c99_kept", 1'b0, 2'd2, 99, c99_before);
    read_expect("abort_a0", 1'b0, 2'd0, 0, 8'd171);
    read_expect("abort_b0", 1'b0, 2'd1, 0, 8'd167);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
